gate_out_filter: RTL and testbench

- Downstream stage for a switch-level gate output, such as the 1-bit output of a cmosnand cell.
- Synchronises the raw gate output into the clk domain and debounces it with a stable-cycle filter.
- Reports filtered rising and falling edges as single-cycle pulses and as a one-entry valid/ready event, and keeps a saturating toggle count.
- Sits between the transistor-level gate models and the register-level test logic that consumes clean gate transitions.

---
 rtl/gate_mon_pkg.sv | 18 +
 rtl/gate_debounce.sv | 74 +++++++
 rtl/gate_out_filter.sv | 81 ++++++++
 tb/tb_gate_out_filter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_mon_pkg.sv
// Shared encodings, defaults and width helper for the gate output monitor.
// Optional build macro: GATE_OUT_FILTER_XZ_CHECK_EN (x/z check on din).
package gate_mon_pkg;

    localparam logic EVT_FALL = 1'b0;
    localparam logic EVT_RISE = 1'b1;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 16;

    // Stable counter width: never narrower than one bit.
    function automatic int stable_cnt_w(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gate_debounce.sv
// Two-flop synchroniser plus stable-cycle debounce filter for one gate output.
// With GATE_OUT_FILTER_XZ_CHECK_EN, x/z on din is flagged and ignored.
module gate_debounce
    import gate_mon_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic level,
    output logic flip,
    output logic sync_val,
    output logic xz_err
);

    localparam int CW = stable_cnt_w(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          s1_d;
    logic [CW-1:0] cnt;
    logic          mismatch;

`ifdef GATE_OUT_FILTER_XZ_CHECK_EN
    logic din_bad;

    assign din_bad = (din === 1'bx) || (din === 1'bz);
    // A floating or contended output is treated as no change.
    assign s1_d    = din_bad ? s1 : din;

    always_ff @(posedge clk) begin
        if (rst) begin
            xz_err <= 1'b0;
        end else if (din_bad) begin
            xz_err <= 1'b1;
        end
    end
`else
    assign s1_d   = din;
    assign xz_err = 1'b0;
`endif

    assign mismatch = en && (s2 != level);
    assign flip     = mismatch && (cnt == LAST);
    assign sync_val = s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= s1_d;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (flip) begin
            cnt   <= '0;
            level <= s2;
        end else if (mismatch) begin
            cnt   <= cnt + CW'(1);
        end else begin
            cnt   <= '0;
        end
    end

endmodule

// File: rtl/gate_out_filter.sv
// Debounced gate output with edge pulses, one-entry event and toggle count.
// Optional build macro: GATE_OUT_FILTER_XZ_CHECK_EN (x/z check on din).
module gate_out_filter
    import gate_mon_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_rise,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_sat,
    output logic             overrun,
    output logic             xz_err
);

    logic flip;
    logic sync_val;
    logic accept;

    gate_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_deb (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .en      (en),
        .level   (level),
        .flip    (flip),
        .sync_val(sync_val),
        .xz_err  (xz_err)
    );

    assign accept  = evt_valid && evt_ready;
    assign cnt_sat = &toggle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= flip && sync_val;
            fall <= flip && !sync_val;
        end
    end

    // A new event may reuse the slot the consumer is emptying this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_rise  <= EVT_FALL;
            overrun   <= 1'b0;
        end else if (flip) begin
            if (!evt_valid || accept) begin
                evt_valid <= 1'b1;
                evt_rise  <= sync_val ? EVT_RISE : EVT_FALL;
            end else begin
                overrun   <= 1'b1;
            end
        end else if (accept) begin
            evt_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_cnt <= '0;
        end else if (flip && !cnt_sat) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gate_out_filter.sv
// Directed bench for gate_out_filter with an event scoreboard queue.
// Main DUT: STABLE_CYCLES=4, CNT_W=3; second DUT: STABLE_CYCLES=1.
module tb_gate_out_filter;
    import gate_mon_pkg::*;

    localparam int SC = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          din;
    logic          en;
    logic          evt_ready;
    logic          level;
    logic          rise;
    logic          fall;
    logic          evt_valid;
    logic          evt_rise;
    logic [CW-1:0] toggle_cnt;
    logic          cnt_sat;
    logic          overrun;
    logic          xz_err;

    logic          u1_ready = 1'b0;
    logic          u1_level;
    logic          u1_rise;
    logic          u1_fall;
    logic          u1_valid;
    logic          u1_evt_rise;
    logic [CW-1:0] u1_cnt;
    logic          u1_sat;
    logic          u1_overrun;
    logic          u1_xz;

    int errors = 0;
    int checks = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    gate_out_filter #(
        .STABLE_CYCLES(SC),
        .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .en(en),
        .level(level), .rise(rise), .fall(fall),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_rise(evt_rise), .toggle_cnt(toggle_cnt),
        .cnt_sat(cnt_sat), .overrun(overrun), .xz_err(xz_err)
    );

    gate_out_filter #(
        .STABLE_CYCLES(1),
        .CNT_W(CW)
    ) dut1 (
        .clk(clk), .rst(rst), .din(din), .en(en),
        .level(u1_level), .rise(u1_rise), .fall(u1_fall),
        .evt_valid(u1_valid), .evt_ready(u1_ready),
        .evt_rise(u1_evt_rise), .toggle_cnt(u1_cnt),
        .cnt_sat(u1_sat), .overrun(u1_overrun), .xz_err(u1_xz)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the expected type, compare the held event, then hand it over.
    task automatic accept(input string tag);
        logic e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        chk({tag, "_valid"}, evt_valid, 1);
        chk({tag, "_type"}, evt_rise, e);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk({tag, "_empty"}, evt_valid, 0);
    endtask

    initial begin
        int seen;
        int exp_cnt;

        rst = 1'b1; din = 1'b1; en = 1'b1; evt_ready = 1'b0;
        tick(2);
        chk("rst_level", level, 0);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_evt_rise", evt_rise, 0);
        chk("rst_cnt", toggle_cnt, 0);
        chk("rst_sat", cnt_sat, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_xz", xz_err, 0);

        // Release with din=1: level rises at edge SC+2 (edge 3 when SC=1).
        rst = 1'b0;
        exp_q.push_back(EVT_RISE);
        tick(2);
        chk("sc1_before", u1_level, 0);
        tick(1);
        chk("sc1_after", u1_level, 1);
        chk("sc1_rise", u1_rise, 1);
        tick(2);
        chk("lat_before", level, 0);
        tick(1);
        chk("lat_level", level, 1);
        chk("lat_rise", rise, 1);
        chk("lat_fall", fall, 0);
        chk("lat_cnt", toggle_cnt, 1);
        accept("ev_rise1");
        chk("rise_pulse_end", rise, 0);

        din = 1'b0;
        exp_q.push_back(EVT_FALL);
        tick(5);
        chk("fall_before", level, 1);
        tick(1);
        chk("fall_level", level, 0);
        chk("fall_pulse", fall, 1);
        chk("fall_norise", rise, 0);
        accept("ev_fall1");

        // Glitch of SC-1 cycles.
        din = 1'b1;
        tick(3);
        din = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (rise || level) seen++;
        end
        chk("glitch_seen", seen, 0);
        chk("glitch_cnt", toggle_cnt, 2);
        chk("glitch_valid", evt_valid, 0);

        // Second event dropped while the first is held.
        din = 1'b1;
        exp_q.push_back(EVT_RISE);
        tick(10);
        din = 1'b0;
        tick(10);
        chk("ovr_level", level, 0);
        chk("ovr_flag", overrun, 1);
        chk("ovr_cnt", toggle_cnt, 4);
        accept("ev_ovr");

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        chk("rst2_overrun", overrun, 0);
        chk("rst2_cnt", toggle_cnt, 0);

        // Accept and load in the same cycle.
        din = 1'b1;
        exp_q.push_back(EVT_RISE);
        tick(10);
        chk("al_level1", level, 1);
        din = 1'b0;
        exp_q.push_back(EVT_FALL);
        tick(5);
        chk("al_pending", level, 1);
        chk("al_held", evt_rise, exp_q.pop_front());
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("al_valid", evt_valid, 1);
        chk("al_fall", fall, 1);
        chk("al_overrun", overrun, 0);
        accept("ev_al");

        // Saturation at 2^CW-1.
        for (int i = 0; i < 9; i++) begin
            din = ~din;
            exp_q.push_back(din);
            tick(6);
            chk("sat_level", level, din);
            exp_cnt = (2 + i + 1 > 7) ? 7 : 2 + i + 1;
            chk("sat_cnt", toggle_cnt, exp_cnt);
            chk("sat_flag", cnt_sat, exp_cnt == 7);
            accept("ev_sat");
        end

        // en=0 freezes the filter; SC edges needed after en returns.
        en = 1'b0;
        din = 1'b0;
        tick(20);
        chk("en0_level", level, 1);
        en = 1'b1;
        exp_q.push_back(EVT_FALL);
        tick(SC - 1);
        chk("en1_before", level, 1);
        tick(1);
        chk("en1_level", level, 0);
        chk("en1_fall", fall, 1);
        chk("en1_cnt", toggle_cnt, 7);
        accept("ev_en");

        // Reset discards a held event and restarts the filter.
        din = 1'b1;
        tick(6);
        chk("mid_held", evt_valid, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        chk("mid_valid", evt_valid, 0);
        chk("mid_level", level, 0);
        chk("mid_cnt", toggle_cnt, 0);
        exp_q.push_back(EVT_RISE);
        tick(SC + 1);
        chk("mid_before", level, 0);
        tick(1);
        chk("mid_after", level, 1);
        accept("ev_mid");

`ifndef GATE_OUT_FILTER_XZ_CHECK_EN
        chk("xz_tied", xz_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
